// File: rtl/apb2axi_pkg.sv
// Shared defaults and width helpers for the APB-to-AXI request arbiter.
// Imported by the arbiter top and its round-robin picker.
package apb2axi_pkg;

   localparam int ARB_NUM_REQ     = 4;
   localparam int ARB_MAX_BURST   = 4;
   localparam int ARB_ENTRY_WIDTH = 64;
   localparam int ARB_CNT_W       = 4;

   function automatic int src_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb2axi_rr_pick.sv
// Combinational modulo priority search: first set bit of req at or after start.
// Returns a one-hot grant, its index and whether any request was found.
module apb2axi_rr_pick
   import apb2axi_pkg::*;
#(
   parameter int N  = ARB_NUM_REQ,
   parameter int IW = src_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW:0]   sum;
   logic [IW-1:0] pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      pos = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, start} + (IW+1)'(k);
         if (sum >= (IW+1)'(N))
            sum = sum - (IW+1)'(N);
         pos = sum[IW-1:0];
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/apb2axi_req_arb.sv
// Round-robin request arbiter with bounded bursts feeding one output register.
// Output register pops and reloads in the same cycle for full throughput.
module apb2axi_req_arb
   import apb2axi_pkg::*;
#(
   parameter int  NUM_REQ     = ARB_NUM_REQ,
   parameter int  ENTRY_WIDTH = ARB_ENTRY_WIDTH,
   parameter int  MAX_BURST   = ARB_MAX_BURST,
   localparam int SRC_W       = src_w(NUM_REQ)
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][ENTRY_WIDTH-1:0] req_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ENTRY_WIDTH-1:0]              out_data,
   output logic [SRC_W-1:0]                    out_src
);

   localparam int CW = ARB_CNT_W;

   logic                   out_valid_q, out_valid_d;
   logic [ENTRY_WIDTH-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]       out_src_q, out_src_d;
   logic [SRC_W-1:0]       last_src_q, last_src_d;
   logic [CW-1:0]          burst_cnt_q, burst_cnt_d;

   logic               load, sticky, any, xfer;
   logic [SRC_W-1:0]   start, pick_idx;
   logic [NUM_REQ-1:0] grant;

   assign load   = !out_valid_q || out_ready;
   assign sticky = (burst_cnt_q != '0)
                && (burst_cnt_q < CW'(MAX_BURST))
                && req_valid[last_src_q];

   // Sticky bursts restart the search at last_src; otherwise it goes last.
   always_comb begin
      start = last_src_q + SRC_W'(1);
      if (sticky)
         start = last_src_q;
      else if (last_src_q == SRC_W'(NUM_REQ-1))
         start = '0;
   end

   apb2axi_rr_pick #(
      .N  (NUM_REQ),
      .IW (SRC_W)
   ) u_pick (
      .req   (req_valid),
      .start (start),
      .gnt   (grant),
      .idx   (pick_idx),
      .any   (any)
   );

   assign xfer      = load && any && resetn;
   assign req_ready = xfer ? grant : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      last_src_d  = last_src_q;
      burst_cnt_d = burst_cnt_q;
      if (load)
         out_valid_d = any;
      if (xfer) begin
         out_data_d = req_data[pick_idx];
         out_src_d  = pick_idx;
         last_src_d = pick_idx;
         if (pick_idx != last_src_q)
            burst_cnt_d = CW'(1);
         else if (burst_cnt_q < CW'(MAX_BURST))
            burst_cnt_d = burst_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         last_src_q  <= SRC_W'(NUM_REQ-1);
         burst_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         last_src_q  <= last_src_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_apb2axi_req_arb.sv
// Directed bench for apb2axi_req_arb with a transfer scoreboard.
// A second instance runs with single-entry bursts.
module tb_apb2axi_req_arb;
   import apb2axi_pkg::*;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int SW = src_w(N);

   logic clk = 1'b0;
   logic resetn;

   logic [N-1:0]        req_valid, req_ready;
   logic [N-1:0][W-1:0] req_data;
   logic                out_valid, out_ready;
   logic [W-1:0]        out_data;
   logic [SW-1:0]       out_src;

   logic [N-1:0]        b_req_valid, b_req_ready;
   logic [N-1:0][W-1:0] b_req_data;
   logic                b_out_valid, b_out_ready;
   logic [W-1:0]        b_out_data;
   logic [SW-1:0]       b_out_src;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [W-1:0]  data;
   } ent_t;

   ent_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   apb2axi_req_arb #(
      .NUM_REQ     (N),
      .ENTRY_WIDTH (W),
      .MAX_BURST   (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   apb2axi_req_arb #(
      .NUM_REQ     (N),
      .ENTRY_WIDTH (W),
      .MAX_BURST   (1)
   ) dut_b (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_data  (b_req_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_src   (b_out_src)
   );

   task automatic chk(input string tag,
                      input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample handshakes before the edge, then advance one cycle.
   task automatic tick();
      ent_t e;
      #1;
      chk("onehot_a", W'($onehot0(req_ready)), 1);
      chk("onehot_b", W'($onehot0(b_req_ready)), 1);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", W'(out_valid), 0);
         end else begin
            e = sb.pop_front();
            chk("sb_src", W'(out_src), W'(e.src));
            chk("sb_data", out_data, e.data);
         end
      end
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i])
            sb.push_back(ent_t'{src: SW'(i), data: req_data[i]});
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp030[12] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1};

      resetn      = 1'b0;
      req_valid   = '1;
      req_data    = '0;
      out_ready   = 1'b1;
      b_req_valid = '0;
      b_out_ready = 1'b1;
      for (int i = 0; i < N; i++)
         b_req_data[i] = W'(i);

      tick();
      tick();
      chk("rst_valid", W'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_src", W'(out_src), 0);
      chk("rst_ready", W'(req_ready), 0);

      // Two requesters alternate in bursts of four.
      resetn    = 1'b1;
      req_valid = 4'b1010;
      for (int j = 0; j < 12; j++) begin
         for (int i = 0; i < N; i++)
            req_data[i] = W'(i * 256 + j);
         tick();
         chk("burst_src", W'(out_src), W'(exp030[j]));
         chk("burst_valid", W'(out_valid), 1);
      end
      req_valid = '0;
      tick();
      chk("drain_valid", W'(out_valid), 0);
      chk("drain_src", W'(out_src), 1);
      chk("drain_data", out_data, 64'h10b);

      // Lone requester streams past the burst limit.
      for (int k = 0; k < 6; k++) begin
         req_valid   = 4'b0100;
         req_data[2] = W'(16 + k);
         #1;
         chk("solo_ready", W'(req_ready), 4'b0100);
         tick();
      end
      req_valid = '0;
      tick();
      chk("solo_last", out_data, 64'h15);

      // Single-entry bursts rotate every cycle.
      b_req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rot_src", W'(b_out_src), W'(k % 4));
         chk("rot_valid", W'(b_out_valid), 1);
      end
      b_req_valid = '0;

      // Backpressure holds the output register.
      req_valid   = 4'b0001;
      req_data[0] = 64'ha0;
      out_ready   = 1'b1;
      tick();
      chk("bp_first", out_data, 64'ha0);
      out_ready   = 1'b0;
      req_data[0] = 64'ha1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready", W'(req_ready), 0);
         tick();
         chk("bp_data", out_data, 64'ha0);
         chk("bp_src", W'(out_src), 0);
         chk("bp_valid", W'(out_valid), 1);
      end
      out_ready   = 1'b1;
      req_data[0] = 64'ha2;
      #1;
      chk("bp_reload", W'(req_ready), 4'b0001);
      tick();
      chk("bp_new", out_data, 64'ha2);

      // Reset mid-burst discards the held entry.
      req_data[0] = 64'ha3;
      tick();
      chk("mid_pre", out_data, 64'ha3);
      resetn = 1'b0;
      #1;
      chk("mid_valid", W'(out_valid), 0);
      chk("mid_ready", W'(req_ready), 0);
      sb.delete();
      tick();
      resetn      = 1'b1;
      req_valid   = 4'b1100;
      req_data[2] = 64'hc2;
      req_data[3] = 64'hc3;
      tick();
      chk("post_src", W'(out_src), 2);
      chk("post_data", out_data, 64'hc2);
      req_valid = '0;
      tick();
      tick();
      chk("sb_left", W'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
